// File: rtl/spi_master_seq.sv
// spi_master_seq: frames one M-bit exchange with a SCLK/LOAD/MOSI/MISO shift-register slave.
// Optional: define SPI_SEQ_LOOPBACK_EN to sample the registered MOSI instead of MISO.
module spi_master_seq #(
    parameter int M   = 9,
    parameter int DIV = 4
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         start,
    input  logic         abort,
    input  logic [M-1:0] tx_data,
    output logic         busy,
    output logic         done,
    output logic [M-1:0] rx_data,
    output logic         SCLK,
    output logic         LOAD,
    output logic         MOSI,
    input  logic         MISO
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = (M > 1) ? $clog2(M) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_TOP  = BW'(M - 1);

    typedef enum logic [2:0] {
        IDLE, LD_HI, LD_GAP, SH_LO, SH_HI, LATCH, DONE
    } state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] div_cnt, div_nxt;
    logic [BW-1:0] bit_cnt, bit_nxt;
    logic [M-1:0]  tx_sr, rx_sr;
    logic          div_end;
    logic          accept;
    logic          sample;
    logic          sample_src;
    logic          sclk_nxt, load_nxt, mosi_nxt;

`ifdef SPI_SEQ_LOOPBACK_EN
    assign sample_src = MOSI;
`else
    assign sample_src = MISO;
`endif

    assign div_end = (div_cnt == DIV_LAST);
    assign accept  = (state == IDLE) && start && !abort;
    // MISO is taken on the edge that moves SH_LO into SH_HI (SCLK rising)
    assign sample  = (state == SH_LO) && div_end && !abort;

    // next-state, counters and next pin levels; abort overrides everything
    always_comb begin
        state_nxt = state;
        div_nxt   = '0;
        bit_nxt   = bit_cnt;
        mosi_nxt  = MOSI;
        if (state != IDLE && abort) begin
            state_nxt = IDLE;
            bit_nxt   = BIT_TOP;
            mosi_nxt  = 1'b0;
        end else begin
            if (state != IDLE && state != DONE) begin
                div_nxt = div_end ? '0 : div_cnt + 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state_nxt = LD_HI;
                        bit_nxt   = BIT_TOP;
                    end
                end
                LD_HI: begin
                    if (div_end) state_nxt = LD_GAP;
                end
                LD_GAP: begin
                    if (div_end) begin
                        state_nxt = SH_LO;
                        mosi_nxt  = tx_sr[bit_cnt];
                    end
                end
                SH_LO: begin
                    if (div_end) state_nxt = SH_HI;
                end
                SH_HI: begin
                    if (div_end) begin
                        if (bit_cnt == '0) begin
                            state_nxt = LATCH;
                        end else begin
                            bit_nxt   = bit_cnt - 1'b1;
                            state_nxt = SH_LO;
                            mosi_nxt  = tx_sr[bit_nxt];
                        end
                    end
                end
                LATCH: begin
                    if (div_end) state_nxt = DONE;
                end
                DONE: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
        sclk_nxt = (state_nxt == SH_HI);
        load_nxt = (state_nxt == LD_HI) || (state_nxt == LATCH);
    end

    // state register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // divider, bit counter and shift registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            div_cnt <= '0;
            bit_cnt <= BIT_TOP;
            tx_sr   <= '0;
            rx_sr   <= '0;
        end else begin
            div_cnt <= div_nxt;
            bit_cnt <= bit_nxt;
            if (accept) tx_sr <= tx_data;
            if (sample) rx_sr <= {rx_sr[M-2:0], sample_src};
        end
    end

    // registered pins, aligned with the state they belong to
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            SCLK <= 1'b0;
            LOAD <= 1'b0;
            MOSI <= 1'b0;
        end else begin
            SCLK <= sclk_nxt;
            LOAD <= load_nxt;
            MOSI <= mosi_nxt;
        end
    end

    // status lags the state by one clk; abort clears it on the same edge
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            rx_data <= '0;
        end else begin
            busy <= (state != IDLE) && !abort;
            done <= (state == DONE) && !abort;
            if (state == DONE && !abort) rx_data <= rx_sr;
        end
    end

endmodule

// File: tb/tb_spi_master_seq.sv
// tb_spi_master_seq: directed checks of spi_master_seq (DIV=4 with slave model, DIV=1 looped).
// Build with SPI_SEQ_LOOPBACK_EN to also cover the loopback self-test.
module tb_spi_master_seq;

    localparam int M = 9;

`ifdef SPI_SEQ_LOOPBACK_EN
    localparam logic [M-1:0] EXP_B = 9'h1C3;
    localparam logic [M-1:0] EXP_C = 9'h0AA;
`else
    localparam logic [M-1:0] EXP_B = 9'h0A5;
    localparam logic [M-1:0] EXP_C = 9'h0A5;
`endif

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [M-1:0] tx_data = '0;
    logic         busy, done, sclk, load, mosi, miso;
    logic [M-1:0] rx_data;

    logic         start1 = 1'b0;
    logic         abort1 = 1'b0;
    logic [M-1:0] tx1 = '0;
    logic         busy1, done1, sclk1, load1, mosi1, miso1;
    logic [M-1:0] rx1;

    assign miso1 = mosi1;

    spi_master_seq #(.M(M), .DIV(4)) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .abort(abort),
        .tx_data(tx_data), .busy(busy), .done(done), .rx_data(rx_data),
        .SCLK(sclk), .LOAD(load), .MOSI(mosi), .MISO(miso)
    );

    spi_master_seq #(.M(M), .DIV(1)) dut1 (
        .clk(clk), .clr_n(clr_n), .start(start1), .abort(abort1),
        .tx_data(tx1), .busy(busy1), .done(done1), .rx_data(rx1),
        .SCLK(sclk1), .LOAD(load1), .MOSI(mosi1), .MISO(miso1)
    );

    // slave shift-register pair model
    logic [M-1:0] s_di = '0, s_tx = '0, s_rx = '0, s_do = '0;
    int           s_rises = 0;
    logic         s_ld_q = 1'b0, s_sc_q = 1'b0;
    logic         tie0 = 1'b0;
    assign miso = tie0 ? 1'b0 : s_tx[M-1];

    always @(sclk or load or clr_n) begin
        if (!clr_n) s_rises = 0;
        if (load && !s_ld_q) begin
            if (s_rises == 0) s_tx = s_di;
            else begin
                s_do = s_rx;
                s_rises = 0;
            end
        end
        if (sclk && !s_sc_q) begin
            s_rx = {s_rx[M-2:0], mosi};
            s_rises++;
        end
        if (!sclk && s_sc_q) s_tx = {s_tx[M-2:0], 1'b0};
        s_ld_q = load;
        s_sc_q = sclk;
    end

    // pin monitors
    int           sc_rises = 0, ld_pulses = 0, ld_cyc = 0, done_cnt = 0;
    int           sc1_rises = 0, sc1_hi = 0, ld1_cyc = 0, ovl = 0;
    logic [M-1:0] mosi_sh = '0;

    always @(posedge sclk) begin
        sc_rises++;
        mosi_sh = {mosi_sh[M-2:0], mosi};
    end
    always @(posedge load) ld_pulses++;
    always @(posedge sclk1) sc1_rises++;

    always @(negedge clk) begin
        if (load) ld_cyc++;
        if (done) done_cnt++;
        if (sclk1) sc1_hi++;
        if (load1) ld1_cyc++;
        if ((sclk && load) || (sclk1 && load1)) ovl++;
        assert (!(sclk && load)) else $error("SCLK/LOAD overlap DIV=4");
        assert (!(sclk1 && load1)) else $error("SCLK/LOAD overlap DIV=1");
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one frame on dut; lat = edges from start edge to done, -1 on timeout
    task automatic run_frame(input logic [M-1:0] tx, output int lat,
                             output logic b1);
        @(negedge clk);
        tx_data = tx;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        b1 = 1'b0;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) b1 = busy;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    int   lat, b_sr, b_lp, b_lc, b_dc, ld2, hit;
    logic b1;

    initial begin
        // reset state
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sclk", sclk, 0);
        check("rst_load", load, 0);
        check("rst_mosi", mosi, 0);
        check("rst_rx", rx_data, 0);
        @(negedge clk);
        clr_n = 1'b1;
        repeat (2) @(negedge clk);

        // basic frame
        s_di = 9'h0A5;
        b_sr = sc_rises; b_lp = ld_pulses; b_lc = ld_cyc; b_dc = done_cnt;
        run_frame(9'h1C3, lat, b1);
        check("b_busy1", b1, 1);
        check("b_lat", lat, 85);
        check("b_rx", rx_data, EXP_B);
        check("b_mosi", mosi_sh, 9'h1C3);
        check("b_slave_do", s_do, 9'h1C3);
        check("b_sclk_rises", sc_rises - b_sr, 9);
        check("b_load_pulses", ld_pulses - b_lp, 2);
        check("b_load_cycles", ld_cyc - b_lc, 8);
        check("b_sclk_end", sclk, 0);
        @(posedge clk);
        #1;
        check("b_done_width", done, 0);
        check("b_busy_end", busy, 0);
        check("b_done_count", done_cnt - b_dc, 1);

        // reset in the middle of SH_HI
        repeat (2) @(negedge clk);
        tx_data = 9'h111;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        hit = 0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            #1;
            if (sclk) begin
                hit = 1;
                break;
            end
        end
        check("g_in_sh_hi", hit, 1);
        check("g_rx_before", rx_data, EXP_B);
        #2 clr_n = 1'b0;
        #1;
        check("g_sclk", sclk, 0);
        check("g_load", load, 0);
        check("g_busy", busy, 0);
        check("g_done", done, 0);
        check("g_rx", rx_data, 0);
        check("g_slave_do", s_do, 9'h1C3);
        @(negedge clk);
        clr_n = 1'b1;
        repeat (2) @(negedge clk);

        // start held high: one frame, next starts right after DONE
        tx_data = 9'h0AA;
        s_di = 9'h0A5;
        start = 1'b1;
        b_dc = done_cnt;
        @(posedge clk);
        #1;
        lat = -1;
        ld2 = -1;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk);
            #1;
            if (done && lat < 0) begin
                lat = n;
                tx_data = 9'h1FF;
                s_di = 9'h1FF;
            end
            if (lat > 0 && load) begin
                ld2 = n;
                break;
            end
        end
        start = 1'b0;
        check("c_lat", lat, 85);
        check("c_restart", ld2, 86);
        check("c_done_count", done_cnt - b_dc, 1);
        check("c_rx", rx_data, EXP_C);

        // abort in SH_LO of bit 4 of the second frame
        for (int k = 87; k <= 127; k++) @(posedge clk);
        #1;
        check("d_pre_sclk", sclk, 0);
        check("d_pre_mosi", mosi, 1);
        abort = 1'b1;
        b_dc = done_cnt;
        @(posedge clk);
        #1 abort = 1'b0;
        check("d_sclk", sclk, 0);
        check("d_load", load, 0);
        check("d_mosi", mosi, 0);
        check("d_busy", busy, 0);
        repeat (100) @(posedge clk);
        #1;
        check("d_no_done", done_cnt - b_dc, 0);
        check("d_rx_kept", rx_data, EXP_C);
        check("d_idle_busy", busy, 0);

        // start and abort together in IDLE
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check("e_load", load, 0);
        @(posedge clk);
        #1;
        check("e_busy", busy, 0);

        // DIV=1, MISO looped to MOSI externally
        @(negedge clk);
        b_sr = sc1_rises; b_lc = sc1_hi; b_lp = ld1_cyc;
        tx1 = 9'h0F0;
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (done1) begin
                lat = n;
                break;
            end
        end
        check("f_lat", lat, 22);
        check("f_rx", rx1, 9'h0F0);
        check("f_sclk_rises", sc1_rises - b_sr, 9);
        check("f_sclk_hi", sc1_hi - b_lc, 9);
        check("f_load_cycles", ld1_cyc - b_lp, 2);

`ifdef SPI_SEQ_LOOPBACK_EN
        // loopback self-test with MISO forced low
        tie0 = 1'b1;
        repeat (2) @(negedge clk);
        run_frame(9'h155, lat, b1);
        check("lb_lat", lat, 85);
        check("lb_rx", rx_data, 9'h155);
`endif

        check("overlap", ovl, 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
